// File: rtl/spi_flash_reader.sv
// SPI mode-0 master issuing READ (0x03) + 24-bit address to the boot flash,
// streaming returned bytes through a single-register valid/ready port.
module spi_flash_reader #(
  parameter int CLK_DIV  = 2,
  parameter int CSB_IDLE = 4,
  parameter int LEN_W    = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             flash_csb,
  output logic             flash_clk,
  output logic             flash_io0,
  input  logic             flash_io1
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CSB_IDLE > 1) ? $clog2(CSB_IDLE) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CSB_IDLE - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, HOLD, FINISH, GAP
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sho_q, sho_d;
  logic [6:0]       shi_q, shi_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             clk_q, clk_d;
  logic             csb_q, csb_d;
  logic             io0_q, io0_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             tick, rise_ok, rise;

  assign tick    = (div_q == DIV_LAST);
  // Output register can take a new byte this cycle
  assign rise_ok = ~valid_q | rd_ready;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      sho_q   <= '0;
      shi_q   <= '0;
      gap_q   <= GAP_LAST;
      clk_q   <= 1'b0;
      csb_q   <= 1'b1;
      io0_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      sho_q   <= sho_d;
      shi_q   <= shi_d;
      gap_q   <= gap_d;
      clk_q   <= clk_d;
      csb_q   <= csb_d;
      io0_q   <= io0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    sho_d   = sho_q;
    shi_d   = shi_q;
    gap_d   = gap_q;
    clk_d   = clk_q;
    csb_d   = csb_q;
    io0_d   = io0_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    valid_d = valid_q & ~rd_ready;
    rise    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          if (len != '0) begin
            cnt_d   = len;
            sho_d   = {8'h03, addr};
            io0_d   = 1'b0;
            bit_d   = '0;
            div_d   = '0;
            clk_d   = 1'b0;
            csb_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = CMD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      CMD, ADDR: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          if (!clk_q) begin
            clk_d = 1'b1;
          end else begin
            clk_d = 1'b0;
            bit_d = bit_q + 5'd1;
            sho_d = {sho_q[30:0], 1'b0};
            io0_d = sho_q[30];
            if (bit_q == 5'd7) state_d = ADDR;
            if (bit_q == 5'd31) begin
              io0_d   = 1'b0;
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          if (clk_q) begin
            clk_d = 1'b0;
          end else if (bit_q == 5'd7 && !rise_ok) begin
            // Park clock low until the output register drains
            state_d = HOLD;
            div_d   = div_q;
          end else begin
            rise = 1'b1;
          end
        end
      end
      HOLD: begin
        if (rise_ok) begin
          rise    = 1'b1;
          state_d = DATA;
          div_d   = '0;
        end
      end
      FINISH: begin
        if (clk_q) begin
          div_d = tick ? '0 : div_q + 1'b1;
          if (tick) clk_d = 1'b0;
        end else if (rise_ok) begin
          csb_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rise) begin
      clk_d = 1'b1;
      shi_d = {shi_q[5:0], flash_io1};
      bit_d = bit_q + 5'd1;
      if (bit_q == 5'd7) begin
        bit_d   = '0;
        data_d  = {shi_q, flash_io1};
        valid_d = 1'b1;
        cnt_d   = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) state_d = FINISH;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = data_q;
  assign rd_valid  = valid_q;
  assign flash_csb = csb_q;
  assign flash_clk = clk_q;
  assign flash_io0 = io0_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural READ-only flash
// whose byte at address a is pat(a).
module tb_spi_flash_reader;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start    = 1'b0;
  logic [23:0] addr     = '0;
  logic [15:0] len      = '0;
  logic        busy, done;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        flash_csb, flash_clk, flash_io0;
  logic        flash_io1 = 1'b0;

  int errors = 0;
  int checks = 0;

  spi_flash_reader #(
    .CLK_DIV (2),
    .CSB_IDLE(4),
    .LEN_W   (16)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .start    (start),
    .addr     (addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .flash_csb(flash_csb),
    .flash_clk(flash_clk),
    .flash_io0(flash_io0),
    .flash_io1(flash_io1)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  function automatic logic bitval(input int a, input int off);
    logic [7:0] b;
    b = pat(a + off / 8);
    return b[7 - (off % 8)];
  endfunction

  // Flash model: command/address in on rising edges, data out on falling
  int          fcnt   = 0;
  logic [31:0] fsr    = '0;
  logic [7:0]  f_cmd  = '0;
  logic [23:0] f_addr = '0;

  always @(posedge flash_clk or posedge flash_csb) begin
    if (flash_csb) begin
      fcnt <= 0;
    end else begin
      if (fcnt < 32) fsr <= {fsr[30:0], flash_io0};
      if (fcnt == 31) begin
        f_cmd  <= fsr[30:23];
        f_addr <= {fsr[22:0], flash_io0};
      end
      fcnt <= fcnt + 1;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_csb && fcnt >= 32)
      flash_io1 <= bitval(int'(f_addr), fcnt - 32);
  end

  // Monitor
  logic [7:0] got[$];
  int   n_done = 0, n_falls = 0, busy_cnt = 0;
  int   lo_run = 0, hi_run = 0, last_lo = 0, last_hi = 0;
  int   first_rise = -1;
  logic prev_csb = 1'b1;

  always @(negedge wb_clk_i) begin
    if (rd_valid && rd_ready) got.push_back(rd_data);
    if (done) n_done <= n_done + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (flash_csb) begin
      hi_run <= prev_csb ? hi_run + 1 : 1;
      if (!prev_csb) last_lo <= lo_run;
    end else begin
      lo_run <= prev_csb ? 1 : lo_run + 1;
      if (prev_csb) begin
        last_hi <= hi_run;
        n_falls <= n_falls + 1;
      end
      if (prev_csb) first_rise <= flash_clk ? 0 : -1;
      else if (flash_clk && first_rise < 0) first_rise <= lo_run;
    end
    prev_csb <= flash_csb;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [23:0] a, input logic [15:0] l);
    @(posedge wb_clk_i); #1;
    start = 1'b1;
    addr  = a;
    len   = l;
    @(posedge wb_clk_i); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge wb_clk_i);
      if (done) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    int  base, nd, nf, nb, hold_bad;
    bit  seen;

    // Reset held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      chk("rst_csb", 32'(flash_csb), 32'd1);
      chk("rst_clk", 32'(flash_clk), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_io0", 32'(flash_io0), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    idle(3);

    // Basic 4-byte read from address 0
    base = got.size();
    nd   = n_done;
    do_start(24'h000000, 16'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_timeout", 600);
    idle(1);
    chk("t1_cmd", 32'(f_cmd), 32'h03);
    chk("t1_addr", 32'(f_addr), 32'h0);
    chk("t1_first_rise", 32'(first_rise), 32'd2);
    chk("t1_nbytes", 32'(got.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_byte%0d", i), 32'(got[base + i]), 32'(pat(i)));
    chk("t1_ndone", 32'(n_done - nd), 32'd1);
    chk("t1_csb_low", 32'(last_lo), 32'd257);
    chk("t1_busy_end", 32'(busy), 32'd0);
    idle(10);

    // Zero-length request
    nd = n_done;
    nf = n_falls;
    nb = busy_cnt;
    do_start(24'h000050, 16'd0);
    @(negedge wb_clk_i);
    chk("z_done_pulse", 32'(done), 32'd1);
    @(negedge wb_clk_i);
    chk("z_done_clear", 32'(done), 32'd0);
    idle(3);
    chk("z_ndone", 32'(n_done - nd), 32'd1);
    chk("z_no_csb", 32'(n_falls - nf), 32'd0);
    chk("z_no_busy", 32'(busy_cnt - nb), 32'd0);
    idle(5);

    // Backpressure: clock must park low while the register is full
    base     = got.size();
    rd_ready = 1'b0;
    do_start(24'h000010, 16'd3);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (rd_valid) seen = 1'b1;
    end
    chk("h_first_valid", 32'(seen), 32'd1);
    hold_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge wb_clk_i);
      if (i >= 50 && (flash_clk || !rd_valid || rd_data !== pat(16)))
        hold_bad++;
    end
    chk("h_frozen", 32'(hold_bad), 32'd0);
    chk("h_flash_edges", 32'(fcnt), 32'd47);
    @(posedge wb_clk_i); #1;
    rd_ready = 1'b1;
    wait_done("h_timeout", 600);
    idle(1);
    chk("h_nbytes", 32'(got.size() - base), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("h_byte%0d", i), 32'(got[base + i]), 32'(pat(16 + i)));
    idle(10);

    // Asynchronous reset in the middle of the address phase
    base = got.size();
    do_start(24'h000123, 16'd2);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (fcnt == 18) seen = 1'b1;
    end
    chk("r_reach_addr10", 32'(seen), 32'd1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("r_csb_async", 32'(flash_csb), 32'd1);
    chk("r_clk_async", 32'(flash_clk), 32'd0);
    chk("r_busy_async", 32'(busy), 32'd0);
    idle(3);
    wb_rst_i = 1'b0;
    idle(2);
    do_start(24'h000100, 16'd1);
    wait_done("r_timeout", 400);
    idle(1);
    chk("r_addr", 32'(f_addr), 32'h100);
    chk("r_nbytes", 32'(got.size() - base), 32'd1);
    chk("r_byte", 32'(got[base]), 32'(pat(256)));
    idle(10);

    // Back-to-back: stray start while busy, then start held through done
    base = got.size();
    nd   = n_done;
    nf   = n_falls;
    do_start(24'h000020, 16'd2);
    idle(20);
    start = 1'b1;
    addr  = 24'h000040;
    len   = 16'd5;
    @(posedge wb_clk_i); #1;
    start = 1'b0;
    addr  = 24'h000030;
    len   = 16'd1;
    seen  = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (done) seen = 1'b1;
    end
    chk("b_done1", 32'(seen), 32'd1);
    start = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (busy) seen = 1'b1;
    end
    chk("b_accept", 32'(seen), 32'd1);
    @(posedge wb_clk_i); #1;
    start = 1'b0;
    wait_done("b_done2", 600);
    idle(1);
    chk("b_nbytes", 32'(got.size() - base), 32'd3);
    chk("b_byte0", 32'(got[base]), 32'(pat(32)));
    chk("b_byte1", 32'(got[base + 1]), 32'(pat(33)));
    chk("b_byte2", 32'(got[base + 2]), 32'(pat(48)));
    chk("b_ndone", 32'(n_done - nd), 32'd2);
    chk("b_nfalls", 32'(n_falls - nf), 32'd2);
    chk("b_csb_gap_ge4", 32'(last_hi >= 4), 32'd1);
    chk("b_addr2", 32'(f_addr), 32'h30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
